// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate type and window-decode helper.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  localparam int unsigned VGA_H_TOTAL  = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  // Half-open window test [lo, hi) in unsigned 10-bit arithmetic.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register shift line; every stage resets to all-ones. DEPTH=0 is a wire.
module sync_delay_line #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '1;
      end else begin
        stage[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: hc/vc counters, visible-region decode and delayed active-low syncs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START_C = coord_t'(HS_START);
  localparam coord_t HS_END_C   = coord_t'(HS_END);
  localparam coord_t VS_START_C = coord_t'(VS_START);
  localparam coord_t VS_END_C   = coord_t'(VS_END);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end
  if (SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end

  coord_t     hc;
  coord_t     vc;
  logic [1:0] sync_raw;
  logic [1:0] sync_dly;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Sync decode ignores reset; the delay line forces the inactive level instead.
  always_comb begin
    blank       = 1'b0;
    line_start  = 1'b0;
    frame_start = 1'b0;
    sync_raw    = '1;
    if (!reset) begin
      blank       = (hc < H_VIS_C) && (vc < V_VIS_C);
      line_start  = (hc == '0);
      frame_start = (hc == '0) && (vc == '0);
    end
    sync_raw[1] = !in_window(hc, HS_START_C, HS_END_C);
    sync_raw[0] = !in_window(vc, VS_START_C, VS_END_C);
  end

  sync_delay_line #(
    .WIDTH (2),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk   (vga_clk),
    .reset (reset),
    .din   (sync_raw),
    .dout  (sync_dly)
  );

  assign DrawX = hc;
  assign DrawY = vc;
  assign hs    = sync_dly[1];
  assign vs    = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks three generator builds (full VGA timing, and a reduced raster with delays 0 and 3) against a cycle-count model.
module tb_vga_timing_gen;

  localparam int SH_V = 8, SH_FP = 2, SH_S = 3, SH_BP = 2;
  localparam int SV_V = 6, SV_FP = 1, SV_S = 2, SV_BP = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   t = 0;
  logic valid = 1'b0;
  int   tests = 0;
  int   errors = 0;
  logic phase1 = 1'b1;

  always #20 clk = ~clk;

  obs_t o0, oa, ob;

  vga_timing_gen #(.SYNC_DELAY(1)) dut0 (
    .vga_clk(clk), .reset(reset), .DrawX(o0.x), .DrawY(o0.y), .blank(o0.blank),
    .hs(o0.hs), .vs(o0.vs), .line_start(o0.ls), .frame_start(o0.fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_VISIBLE(SV_V), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP), .SYNC_DELAY(0)
  ) duta (
    .vga_clk(clk), .reset(reset), .DrawX(oa.x), .DrawY(oa.y), .blank(oa.blank),
    .hs(oa.hs), .vs(oa.vs), .line_start(oa.ls), .frame_start(oa.fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_VISIBLE(SV_V), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP), .SYNC_DELAY(3)
  ) dutb (
    .vga_clk(clk), .reset(reset), .DrawX(ob.x), .DrawY(ob.y), .blank(ob.blank),
    .hs(ob.hs), .vs(ob.vs), .line_start(ob.ls), .frame_start(ob.fs)
  );

  // t = cycles since the last clock edge that sampled reset high.
  always @(posedge clk) begin
    if (reset) begin
      t     <= 0;
      valid <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  function automatic obs_t model(input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input int d, input int tc, input logic r);
    obs_t o;
    int ht, vt, x, y, xd, yd;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    x  = tc % ht;
    y  = (tc / ht) % vt;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = !r && (x < hv) && (y < vv);
    o.ls    = !r && (x == 0);
    o.fs    = !r && (x == 0) && (y == 0);
    o.hs    = 1'b1;
    o.vs    = 1'b1;
    if (tc >= d) begin
      xd   = (tc - d) % ht;
      yd   = ((tc - d) / ht) % vt;
      o.hs = !((xd >= hv + hf) && (xd < hv + hf + hsw));
      o.vs = !((yd >= vv + vf) && (yd < vv + vf + vsw));
    end
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b",
               name, t, act.x, act.y, act.blank, act.hs, act.vs, act.ls, act.fs,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.ls, exp.fs);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Measurements over the first uninterrupted stretch after the initial reset.
  int hs0_low = 0, hs0_first_x = -1, blank0_fall_x = -1;
  int lsb_cnt = 0, blankb_cnt = 0, vsb_low = 0, fsb_cnt = 0, hsb_first_x = -1;
  int vsa_low = 0, hsa_first_x = -1;

  always @(negedge clk) begin
    if (valid) begin
      check_obs("vga640", o0, model(640, 16, 96, 48, 480, 10, 2, 33, 1, t, reset));
      check_obs("small_d0", oa, model(SH_V, SH_FP, SH_S, SH_BP, SV_V, SV_FP, SV_S, SV_BP, 0, t, reset));
      check_obs("small_d3", ob, model(SH_V, SH_FP, SH_S, SH_BP, SV_V, SV_FP, SV_S, SV_BP, 3, t, reset));
      if (phase1 && !reset) begin
        if (t < 800) begin
          if (!o0.hs) begin
            hs0_low++;
            if (hs0_first_x < 0) hs0_first_x = int'(o0.x);
          end
          if (!o0.blank && blank0_fall_x < 0) blank0_fall_x = int'(o0.x);
        end
        if (t < 165) begin
          lsb_cnt    += int'(ob.ls);
          blankb_cnt += int'(ob.blank);
          vsb_low    += int'(!ob.vs);
          vsa_low    += int'(!oa.vs);
        end
        if (t < 330) fsb_cnt += int'(ob.fs);
        if (!ob.hs && hsb_first_x < 0) hsb_first_x = int'(ob.x);
        if (!oa.hs && hsa_first_x < 0) hsa_first_x = int'(oa.x);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_lit("rel_x", int'(o0.x), 0);
    check_lit("rel_y", int'(o0.y), 0);
    check_lit("rel_blank", int'(o0.blank), 1);
    check_lit("rel_fs", int'(o0.fs), 1);
    check_lit("rel_hs", int'(o0.hs), 1);
    check_lit("rel_vs", int'(o0.vs), 1);

    while (t != 1499) @(negedge clk);
    @(posedge clk);
    #1 phase1 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_lit("mid_reset_x", int'(o0.x), 700);
    check_lit("mid_reset_y", int'(o0.y), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_lit("restart_x", int'(o0.x), 0);
    check_lit("restart_y", int'(o0.y), 0);
    check_lit("restart_fs", int'(o0.fs), 1);
    check_lit("restart_hs", int'(o0.hs), 1);

    check_lit("hs_low_cycles", hs0_low, 96);
    check_lit("hs_first_low_x", hs0_first_x, 657);
    check_lit("blank_fall_x", blank0_fall_x, 640);
    check_lit("d3_line_starts", lsb_cnt, 11);
    check_lit("d3_visible", blankb_cnt, 48);
    check_lit("d3_vs_low", vsb_low, 30);
    check_lit("d3_frame_starts", fsb_cnt, 2);
    check_lit("d3_hs_fall_x", hsb_first_x, 13);
    check_lit("d0_hs_fall_x", hsa_first_x, 10);
    check_lit("d0_vs_low", vsa_low, 30);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 700)) @(posedge clk);
      #1 reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (200) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
